// File: rtl/apb_arbiter_pkg.sv
// Shared types and helpers for the APB requester arbiter and its round-robin picker.
package apb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_priority_pick
    import apb_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned LW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt_onehot,
    output logic [LW-1:0] gnt_idx,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!any && (|(req & (N'(1) << idx)))) begin
                any        = 1'b1;
                gnt_idx    = LW'(idx);
                gnt_onehot = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one downstream APB port among N_MASTERS requesters with round-robin grant;
// the winner's request is latched and replayed as a fresh SETUP/ACCESS downstream.
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter int unsigned W_ADDR    = 16,
    parameter int unsigned W_DATA    = 32,
    parameter int unsigned N_MASTERS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS*W_ADDR-1:0]   apbs_paddr,
    input  logic [N_MASTERS-1:0]          apbs_psel,
    input  logic [N_MASTERS-1:0]          apbs_penable,
    input  logic [N_MASTERS-1:0]          apbs_pwrite,
    input  logic [N_MASTERS*W_DATA-1:0]   apbs_pwdata,
    output logic [N_MASTERS-1:0]          apbs_pready,
    output logic [N_MASTERS*W_DATA-1:0]   apbs_prdata,
    output logic [N_MASTERS-1:0]          apbs_pslverr,
    output logic [W_ADDR-1:0]             apbm_paddr,
    output logic                          apbm_psel,
    output logic                          apbm_penable,
    output logic                          apbm_pwrite,
    output logic [W_DATA-1:0]             apbm_pwdata,
    input  logic                          apbm_pready,
    input  logic [W_DATA-1:0]             apbm_prdata,
    input  logic                          apbm_pslverr,
    output logic [N_MASTERS-1:0]          grant
);

    localparam int unsigned LW = idx_width(N_MASTERS);

    apb_state_e              state_q;
    logic [LW-1:0]           last_q;
    logic [N_MASTERS-1:0]    grant_q;
    logic [W_ADDR-1:0]       paddr_q;
    logic [W_DATA-1:0]       pwdata_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;

    logic [N_MASTERS-1:0]    pick_onehot;
    logic [LW-1:0]           pick_idx;
    logic                    pick_any;
    logic                    win_write;
    logic [W_ADDR-1:0]       win_addr;
    logic [W_DATA-1:0]       win_wdata;
    logic                    xfer_done;
    logic                    unused_penable;

    // Requester enables carry no arbitration meaning here.
    assign unused_penable = ^apbs_penable;

    rr_priority_pick #(
        .N  (N_MASTERS),
        .LW (LW)
    ) u_pick (
        .req        (apbs_psel),
        .last       (last_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    // One-hot AND-OR steering of the winner's request; constant indices only.
    logic [W_ADDR-1:0] addr_acc  [N_MASTERS+1];
    logic [W_DATA-1:0] wdata_acc [N_MASTERS+1];

    assign addr_acc[0]  = '0;
    assign wdata_acc[0] = '0;
    for (genvar g = 0; g < N_MASTERS; g++) begin : g_steer
        assign addr_acc[g+1]  = addr_acc[g] |
                                (apbs_paddr[g*W_ADDR +: W_ADDR] & {W_ADDR{pick_onehot[g]}});
        assign wdata_acc[g+1] = wdata_acc[g] |
                                (apbs_pwdata[g*W_DATA +: W_DATA] & {W_DATA{pick_onehot[g]}});
    end
    assign win_addr  = addr_acc[N_MASTERS];
    assign win_wdata = wdata_acc[N_MASTERS];
    assign win_write = |(apbs_pwrite & pick_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= LW'(N_MASTERS - 1);
            grant_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q   <= SETUP;
                        paddr_q   <= win_addr;
                        pwdata_q  <= win_wdata;
                        pwrite_q  <= win_write;
                        grant_q   <= pick_onehot;
                        last_q    <= pick_idx;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (apbm_pready) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        grant_q   <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    grant_q   <= '0;
                end
            endcase
        end
    end

    assign xfer_done    = (state_q == ACCESS) && apbm_pready;
    assign apbs_pready  = grant_q & {N_MASTERS{xfer_done}};
    assign apbs_pslverr = grant_q & {N_MASTERS{xfer_done & apbm_pslverr}};
    assign apbs_prdata  = {N_MASTERS{apbm_prdata}};

    assign apbm_paddr   = paddr_q;
    assign apbm_psel    = psel_q;
    assign apbm_penable = penable_q;
    assign apbm_pwrite  = pwrite_q;
    assign apbm_pwdata  = pwdata_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: per-cycle vector table plus wait-state, reset and drop-out sequences.
module tb_apb_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned WA = 16;
    localparam int unsigned WD = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM*WA-1:0]  apbs_paddr;
    logic [NM-1:0]     apbs_psel;
    logic [NM-1:0]     apbs_penable;
    logic [NM-1:0]     apbs_pwrite;
    logic [NM*WD-1:0]  apbs_pwdata;
    logic [NM-1:0]     apbs_pready;
    logic [NM*WD-1:0]  apbs_prdata;
    logic [NM-1:0]     apbs_pslverr;
    logic [WA-1:0]     apbm_paddr;
    logic              apbm_psel;
    logic              apbm_penable;
    logic              apbm_pwrite;
    logic [WD-1:0]     apbm_pwdata;
    logic              apbm_pready;
    logic [WD-1:0]     apbm_prdata;
    logic              apbm_pslverr;
    logic [NM-1:0]     grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_arbiter #(
        .W_ADDR    (WA),
        .W_DATA    (WD),
        .N_MASTERS (NM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_paddr   (apbs_paddr),
        .apbs_psel    (apbs_psel),
        .apbs_penable (apbs_penable),
        .apbs_pwrite  (apbs_pwrite),
        .apbs_pwdata  (apbs_pwdata),
        .apbs_pready  (apbs_pready),
        .apbs_prdata  (apbs_prdata),
        .apbs_pslverr (apbs_pslverr),
        .apbm_paddr   (apbm_paddr),
        .apbm_psel    (apbm_psel),
        .apbm_penable (apbm_penable),
        .apbm_pwrite  (apbm_pwrite),
        .apbm_pwdata  (apbm_pwdata),
        .apbm_pready  (apbm_pready),
        .apbm_prdata  (apbm_prdata),
        .apbm_pslverr (apbm_pslverr),
        .grant        (grant)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  psel;
        logic        merr;
        logic        e_psel;
        logic        e_pen;
        logic [1:0]  e_grant;
        logic [1:0]  e_sp;
        logic [1:0]  e_serr;
        logic [15:0] e_addr;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic setv(input int i, input logic rst, input logic [1:0] psel, input logic merr,
                        input logic eps, input logic epe, input logic [1:0] eg,
                        input logic [1:0] esp, input logic [1:0] eser, input logic [15:0] ea);
        vecs[i].rst     = rst;
        vecs[i].psel    = psel;
        vecs[i].merr    = merr;
        vecs[i].e_psel  = eps;
        vecs[i].e_pen   = epe;
        vecs[i].e_grant = eg;
        vecs[i].e_sp    = esp;
        vecs[i].e_serr  = eser;
        vecs[i].e_addr  = ea;
    endtask

    // Apply inputs at the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic [1:0] psel, input logic mready, input logic merr);
        @(negedge clk);
        apbs_psel    = psel;
        apbm_pready  = mready;
        apbm_pslverr = merr;
        #1;
    endtask

    int pulses;

    initial begin
        rst_n        = 1'b0;
        apbs_paddr   = {16'h8000, 16'h4004};
        apbs_pwdata  = {32'h12345678, 32'hA5A5A5A5};
        apbs_pwrite  = 2'b10;
        apbs_penable = 2'b00;
        apbs_psel    = 2'b00;
        apbm_pready  = 1'b1;
        apbm_prdata  = 32'hDEADBEEF;
        apbm_pslverr = 1'b0;

        // rst psel merr | psel pen grant pready pslverr addr
        setv( 0, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv( 1, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv( 2, 0, 2'b01, 0, 1, 0, 2'b01, 2'b00, 2'b00, 16'h4004);
        setv( 3, 0, 2'b01, 0, 1, 1, 2'b01, 2'b01, 2'b00, 16'h4004);
        setv( 4, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv( 5, 1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv( 6, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv( 7, 0, 2'b11, 0, 1, 0, 2'b01, 2'b00, 2'b00, 16'h4004);
        setv( 8, 0, 2'b11, 0, 1, 1, 2'b01, 2'b01, 2'b00, 16'h4004);
        setv( 9, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv(10, 0, 2'b11, 0, 1, 0, 2'b10, 2'b00, 2'b00, 16'h8000);
        setv(11, 0, 2'b11, 0, 1, 1, 2'b10, 2'b10, 2'b00, 16'h8000);
        setv(12, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv(13, 0, 2'b11, 0, 1, 0, 2'b01, 2'b00, 2'b00, 16'h4004);
        setv(14, 0, 2'b11, 0, 1, 1, 2'b01, 2'b01, 2'b00, 16'h4004);
        setv(15, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);
        setv(16, 0, 2'b11, 0, 1, 0, 2'b10, 2'b00, 2'b00, 16'h8000);
        setv(17, 0, 2'b11, 1, 1, 1, 2'b10, 2'b10, 2'b10, 16'h8000);
        setv(18, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n        = ~vecs[i].rst;
            apbs_psel    = vecs[i].psel;
            apbm_pready  = 1'b1;
            apbm_pslverr = vecs[i].merr;
            #1;
            chk($sformatf("v%0d psel", i),    32'(apbm_psel),    32'(vecs[i].e_psel));
            chk($sformatf("v%0d penable", i), 32'(apbm_penable), 32'(vecs[i].e_pen));
            chk($sformatf("v%0d grant", i),   32'(grant),        32'(vecs[i].e_grant));
            chk($sformatf("v%0d pready", i),  32'(apbs_pready),  32'(vecs[i].e_sp));
            chk($sformatf("v%0d pslverr", i), 32'(apbs_pslverr), 32'(vecs[i].e_serr));
            if (vecs[i].e_psel) begin
                chk($sformatf("v%0d paddr", i),  32'(apbm_paddr),  32'(vecs[i].e_addr));
                chk($sformatf("v%0d pwrite", i), 32'(apbm_pwrite), 32'(vecs[i].e_grant[1]));
            end
            if (vecs[i].e_sp != 2'b00) begin
                chk($sformatf("v%0d prdata0", i), apbs_prdata[31:0],  32'hDEADBEEF);
                chk($sformatf("v%0d prdata1", i), apbs_prdata[63:32], 32'hDEADBEEF);
            end
        end

        // Wait states: requester 1 writes 0x12345678 to 0x8000, four stalled ACCESS cycles.
        pulses = 0;
        cyc(2'b10, 1'b0, 1'b0);
        chk("ws idle grant", 32'(grant), 32'h0);
        cyc(2'b10, 1'b0, 1'b0);
        chk("ws setup grant",  32'(grant),        32'h2);
        chk("ws setup penable", 32'(apbm_penable), 32'h0);
        chk("ws setup paddr",  32'(apbm_paddr),   32'h8000);
        chk("ws setup pwdata", apbm_pwdata,       32'h12345678);
        for (int w = 0; w < 4; w++) begin
            cyc(2'b10, 1'b0, 1'b0);
            if (apbs_pready != 2'b00) pulses++;
            chk($sformatf("ws%0d psel", w),    32'(apbm_psel),    32'h1);
            chk($sformatf("ws%0d penable", w), 32'(apbm_penable), 32'h1);
            chk($sformatf("ws%0d paddr", w),   32'(apbm_paddr),   32'h8000);
            chk($sformatf("ws%0d pwdata", w),  apbm_pwdata,       32'h12345678);
            chk($sformatf("ws%0d pwrite", w),  32'(apbm_pwrite),  32'h1);
            chk($sformatf("ws%0d pready", w),  32'(apbs_pready),  32'h0);
        end
        cyc(2'b10, 1'b1, 1'b0);
        if (apbs_pready != 2'b00) pulses++;
        chk("ws done pready", 32'(apbs_pready), 32'h2);
        cyc(2'b00, 1'b0, 1'b0);
        if (apbs_pready != 2'b00) pulses++;
        chk("ws idle psel",   32'(apbm_psel),  32'h0);
        chk("ws idle grant2", 32'(grant),      32'h0);
        chk("ws hold paddr",  32'(apbm_paddr), 32'h8000);
        chk("ws hold pwdata", apbm_pwdata,     32'h12345678);
        chk("ws pulse count", 32'(pulses),     32'd1);

        // Asynchronous reset in the middle of requester 1's ACCESS phase.
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        chk("ar access penable", 32'(apbm_penable), 32'h1);
        chk("ar access grant",   32'(grant),        32'h2);
        #1;
        apbm_pready = 1'b1;
        rst_n       = 1'b0;
        #1;
        chk("ar psel",    32'(apbm_psel),    32'h0);
        chk("ar penable", 32'(apbm_penable), 32'h0);
        chk("ar pwrite",  32'(apbm_pwrite),  32'h0);
        chk("ar grant",   32'(grant),        32'h0);
        chk("ar paddr",   32'(apbm_paddr),   32'h0);
        chk("ar pwdata",  apbm_pwdata,       32'h0);
        chk("ar pready",  32'(apbs_pready),  32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        apbs_psel = 2'b11;
        #1;
        chk("ar rel grant", 32'(grant), 32'h0);
        cyc(2'b11, 1'b1, 1'b0);
        chk("ar next grant", 32'(grant), 32'h1);
        cyc(2'b11, 1'b1, 1'b0);
        chk("ar next pready", 32'(apbs_pready), 32'h1);

        // Requester 1 requests while 0 owns the bus, then withdraws before it is served.
        cyc(2'b01, 1'b1, 1'b0);
        chk("dr idle grant", 32'(grant), 32'h0);
        cyc(2'b11, 1'b1, 1'b0);
        chk("dr setup grant", 32'(grant), 32'h1);
        cyc(2'b01, 1'b1, 1'b0);
        chk("dr access pready", 32'(apbs_pready), 32'h1);
        for (int d = 0; d < 2; d++) begin
            cyc(2'b00, 1'b1, 1'b0);
            chk($sformatf("dr idle%0d psel", d),  32'(apbm_psel), 32'h0);
            chk($sformatf("dr idle%0d grant", d), 32'(grant),     32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
